// File: rtl/imm_decode_stage_pkg.sv
// imm_decode_stage_pkg: opcodes, format enum and decoded-entry struct shared by the decode stage
package imm_decode_stage_pkg;
   localparam int PC_MAX_W = 64;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OP32   = 7'b0111011;
   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } imm_fmt_t;
   typedef struct packed {
      logic [31:0]         instr;
      logic [PC_MAX_W-1:0] pc;
      logic [31:0]         imm;
      imm_fmt_t            fmt;
      logic                illegal;
   } entry_t;
endpackage

// File: rtl/imm_decode_stage_extract.sv
// imm_extract: combinational RV64 immediate extraction and format classification
module imm_extract
   import imm_decode_stage_pkg::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm,
   output imm_fmt_t    fmt,
   output logic        illegal
);
   // classify the opcode and assemble the sign-extended immediate for its format
   always_comb begin
      imm = '0;
      fmt = FMT_R;
      illegal = 1'b0;
      case (instr[6:0])
         OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: begin
            fmt = FMT_I;
            imm = {{20{instr[31]}}, instr[31:20]};
         end
         OP_STORE: begin
            fmt = FMT_S;
            imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OP_BRANCH: begin
            fmt = FMT_B;
            imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            fmt = FMT_U;
            imm = {instr[31:12], 12'b0};
         end
         OP_JAL: begin
            fmt = FMT_J;
            imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         OP_OP, OP_OP32: fmt = FMT_R;
         default: illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered decode stage with valid/ready handshake; IMM_DECODE_SKID_EN adds a one-entry skid buffer
module imm_decode_stage
   import imm_decode_stage_pkg::*;
#(
   parameter int PC_WIDTH = 64
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic [31:0]         i_instr,
   input  logic [PC_WIDTH-1:0] i_pc,
   input  logic                i_flush,
   output logic                o_valid,
   input  logic                i_ready,
   output logic [31:0]         o_instr,
   output logic [PC_WIDTH-1:0] o_pc,
   output logic [31:0]         o_imm,
   output logic [2:0]          o_fmt,
   output logic                o_illegal
);
   entry_t   dec, out;
   logic     out_v, rdy_q, in_xfer;
   logic [31:0] x_imm;
   imm_fmt_t x_fmt;
   logic     x_ill;
`ifdef IMM_DECODE_SKID_EN
   entry_t   sk;
   logic     sk_v;
`endif

   imm_extract u_extract (
      .instr   (i_instr),
      .imm     (x_imm),
      .fmt     (x_fmt),
      .illegal (x_ill)
   );

   assign dec = '{instr: i_instr, pc: PC_MAX_W'(i_pc), imm: x_imm, fmt: x_fmt, illegal: x_ill};
`ifdef IMM_DECODE_SKID_EN
   assign o_ready = rdy_q;
`else
   assign o_ready = rdy_q && (!out_v || i_ready);
`endif
   assign in_xfer   = i_valid && o_ready;
   assign o_valid   = out_v;
   assign o_instr   = out.instr;
   assign o_pc      = PC_WIDTH'(out.pc);
   assign o_imm     = out.imm;
   assign o_fmt     = out.fmt;
   assign o_illegal = out.illegal;

   // advance the output slot when it is empty or being consumed; otherwise park a new entry in the skid
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         out_v <= 1'b0;
         out   <= '0;
         rdy_q <= 1'b0;
`ifdef IMM_DECODE_SKID_EN
         sk_v  <= 1'b0;
         sk    <= '0;
`endif
      end else if (i_flush) begin
         out_v <= 1'b0;
         rdy_q <= 1'b1;
`ifdef IMM_DECODE_SKID_EN
         sk_v  <= 1'b0;
`endif
      end else begin
`ifdef IMM_DECODE_SKID_EN
         if (!out_v || i_ready) begin
            out_v <= sk_v || in_xfer;
            if (sk_v) out <= sk;
            else if (in_xfer) out <= dec;
            sk_v  <= 1'b0;
            rdy_q <= 1'b1;
         end else if (in_xfer) begin
            sk    <= dec;
            sk_v  <= 1'b1;
            rdy_q <= 1'b0;
         end
`else
         rdy_q <= 1'b1;
         if (!out_v || i_ready) begin
            out_v <= in_xfer;
            if (in_xfer) out <= dec;
         end
`endif
      end
   end
endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter PC_WIDTH, default 64: width of the carried program counter.
REQ-002 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  reset; asynchronous, active-high.
REQ-004 i_valid  input  1  upstream instruction valid.
REQ-005 o_ready  output  1  stage can accept an instruction.
REQ-006 i_instr  input  32  raw RV64 instruction word.
REQ-007 i_pc  input  PC_WIDTH  instruction address.
REQ-008 i_flush  input  1  discard all held instructions.
REQ-009 o_valid  output  1  decoded entry valid.
REQ-010 i_ready  input  1  downstream accepts entry.
REQ-011 o_instr / o_pc  output  32 / PC_WIDTH  registered copies of accepted i_instr / i_pc.
REQ-012 o_imm  output  32  immediate, sign-extended to 32 bits, fed to the 32-to-64 sign extender downstream.
REQ-013 o_fmt  output  3  format: R=0, I=1, S=2, B=3, U=4, J=5.
REQ-014 o_illegal  output  1  opcode not recognised.

Function
REQ-015 Transfer in when i_valid && o_ready; transfer out when o_valid && i_ready; latency in->out exactly 1 cycle when unstalled.
REQ-016 I (opcodes 0000011, 0010011, 0011011, 1100111, 1110011): imm = sext(instr[31:20]).
REQ-017 S (0100011): imm = sext({instr[31:25], instr[11:7]}).
REQ-018 B (1100011): imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
REQ-019 U (0110111, 0010111): imm = {instr[31:12], 12'b0}.
REQ-020 J (1101111): imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
REQ-021 R (0110011, 0111011): imm = 0, fmt R.
REQ-022 Any other opcode: imm = 0, fmt R, o_illegal = 1; entry still passes through.
REQ-023 Held outputs stable while o_valid && !i_ready; no loss, duplication or reordering.
REQ-024 i_flush: next edge clears o_valid and all buffered entries; an input transferring in the flush cycle is dropped; o_ready is 1 the cycle after flush.
REQ-025 Simultaneous in and out transfer with a single occupied slot: slot is replaced, stays valid.

Reset
REQ-026 While i_rst is high, o_valid = 0, o_ready = 0, o_instr = 0, o_pc = 0, o_imm = 0, o_fmt = 0, o_illegal = 0, skid empty.
REQ-027 o_ready rises on the first edge after i_rst deasserts; reset mid-transfer discards all entries.

Configuration
REQ-028 Macro IMM_DECODE_SKID_EN defined: one-entry skid buffer; o_ready is a flop output = !skid_full; accepted input during stall goes to skid and promotes to output on next downstream accept; throughput 1/cycle.
REQ-029 IMM_DECODE_SKID_EN undefined: single output register; o_ready = !o_valid || i_ready (combinational path from i_ready).

Structure
REQ-030 Shared package holds opcode localparams, the imm_fmt_t enum (R, I, S, B, U, J) and a decoded-entry struct (instr, pc, imm, fmt, illegal).
REQ-031 Combinational extraction lives in sub-module imm_extract (instr in; imm, fmt, illegal out); imm_decode_stage holds only handshake and storage.

Verification
REQ-032 i_instr=0xFFF00093 (addi x1,x0,-1), i_ready=1 -> next cycle o_valid=1, o_imm=0xFFFFFFFF, o_fmt=I.
REQ-033 i_instr=0xFE112E23 (sw x1,-4(x2)) -> o_imm=0xFFFFFFFC, fmt S; i_instr=0x123452B7 (lui) -> o_imm=0x12345000, fmt U.
REQ-034 i_instr=0x0000007F -> o_illegal=1, o_imm=0, o_fmt=R.
REQ-035 Three back-to-back instructions, i_ready low 3 cycles -> all three emerge in order with correct pc; none dropped in either macro setting.
REQ-036 i_flush with two entries held -> o_valid=0 next cycle, input of flush cycle absent from output.
REQ-037 i_rst pulsed asynchronously mid-stream -> outputs zero immediately, o_ready=1 after first post-reset edge.
